// File: rtl/conv_transpose3d_tap_scheduler.sv
// Gather-form tap sequencer for a cubic 3D transposed convolution: walks every output voxel,
// emits one MAC command per valid (input, weight) tap and a COMMIT after each voxel.
module conv_transpose3d_tap_scheduler #(
   parameter int unsigned IN_SIZE = 4,
   parameter int unsigned K       = 3,
   parameter int unsigned STRIDE  = 2,
   parameter int unsigned PAD     = 1,
   parameter int unsigned DIL     = 2,
   parameter int unsigned CIN     = 1,
   parameter int unsigned COUT    = 1,
   parameter int unsigned AW      = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic          cmd_valid,
   input  logic          cmd_ready,
   output logic          cmd_op,
   output logic          cmd_first,
   output logic [AW-1:0] cmd_in_addr,
   output logic [AW-1:0] cmd_w_addr,
   output logic [AW-1:0] cmd_out_addr
);

   localparam int unsigned OUT_SIZE = (IN_SIZE - 1) * STRIDE - 2 * PAD + DIL * (K - 1) + 1;
   localparam int unsigned OCW  = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
   localparam int unsigned KCW  = (K > 1) ? $clog2(K) : 1;
   localparam int unsigned CICW = (CIN > 1) ? $clog2(CIN) : 1;
   localparam int unsigned COCW = (COUT > 1) ? $clog2(COUT) : 1;
   localparam int unsigned NW   = $clog2(OUT_SIZE + PAD + 1) + 2;

   localparam longint unsigned Span     = 64'd1 << AW;
   localparam longint unsigned InWords  = 64'(CIN) * IN_SIZE * IN_SIZE * IN_SIZE;
   localparam longint unsigned WWords   = 64'(CIN) * COUT * K * K * K;
   localparam longint unsigned OutWords = 64'(COUT) * OUT_SIZE * OUT_SIZE * OUT_SIZE;

   if (InWords > Span || WWords > Span || OutWords > Span || STRIDE < 1 || DIL < 1 || K < 1)
   begin : g_cfg_check
      $error("conv_transpose3d_tap_scheduler: configuration does not fit the address width");
   end

   typedef enum logic [1:0] {StIdle, StScan, StCommit, StDone} state_e;

   state_e          state_q, state_d;
   logic [COCW-1:0] co_q, co_d;
   logic [OCW-1:0]  od_q, od_d, oh_q, oh_d, ow_q, ow_d;
   logic [CICW-1:0] ci_q, ci_d;
   logic [KCW-1:0]  kd_q, kd_d, kh_q, kh_d, kw_q, kw_d;
   logic            first_q, first_d;

   logic [AW:0]     ev_d, ev_h, ev_w;
   logic            tap_valid, last_tap, last_vox;

   // Returns {valid, input index} for one dimension of the gather-form tap.
   function automatic logic [AW:0] tap_eval(input logic [OCW-1:0] o, input logic [KCW-1:0] k);
      logic signed [NW-1:0] n;
      logic [NW-1:0]        q;
      logic                 ok;
      n  = NW'(o) + NW'(PAD) - NW'(k) * NW'(DIL);
      q  = $unsigned(n) / NW'(STRIDE);
      ok = !n[NW-1] && (($unsigned(n) % NW'(STRIDE)) == '0) && (32'(q) < IN_SIZE);
      return {ok, AW'(q)};
   endfunction

   always_comb begin
      ev_d      = tap_eval(od_q, kd_q);
      ev_h      = tap_eval(oh_q, kh_q);
      ev_w      = tap_eval(ow_q, kw_q);
      tap_valid = ev_d[AW] & ev_h[AW] & ev_w[AW];
      last_tap  = (ci_q == CICW'(CIN - 1)) && (kd_q == KCW'(K - 1)) &&
                  (kh_q == KCW'(K - 1)) && (kw_q == KCW'(K - 1));
      last_vox  = (co_q == COCW'(COUT - 1)) && (od_q == OCW'(OUT_SIZE - 1)) &&
                  (oh_q == OCW'(OUT_SIZE - 1)) && (ow_q == OCW'(OUT_SIZE - 1));
   end

   // Outputs depend only on registered state, so they hold still while a command is stalled.
   always_comb begin
      busy         = (state_q == StScan) || (state_q == StCommit);
      done         = (state_q == StDone);
      cmd_valid    = 1'b0;
      cmd_op       = 1'b0;
      cmd_first    = 1'b0;
      cmd_in_addr  = '0;
      cmd_w_addr   = '0;
      cmd_out_addr = '0;
      if ((state_q == StScan && tap_valid) || state_q == StCommit) begin
         cmd_valid    = 1'b1;
         cmd_out_addr = ((AW'(co_q) * AW'(OUT_SIZE) + AW'(od_q)) * AW'(OUT_SIZE) + AW'(oh_q))
                        * AW'(OUT_SIZE) + AW'(ow_q);
      end
      if (state_q == StScan && tap_valid) begin
         cmd_first   = first_q;
         cmd_in_addr = ((AW'(ci_q) * AW'(IN_SIZE) + ev_d[AW-1:0]) * AW'(IN_SIZE) + ev_h[AW-1:0])
                       * AW'(IN_SIZE) + ev_w[AW-1:0];
         cmd_w_addr  = (((AW'(ci_q) * AW'(COUT) + AW'(co_q)) * AW'(K) + AW'(kd_q)) * AW'(K)
                       + AW'(kh_q)) * AW'(K) + AW'(kw_q);
      end
      if (state_q == StCommit) begin
         cmd_op = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      co_d    = co_q;
      od_d    = od_q;
      oh_d    = oh_q;
      ow_d    = ow_q;
      ci_d    = ci_q;
      kd_d    = kd_q;
      kh_d    = kh_q;
      kw_d    = kw_q;
      first_d = first_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StScan;
               first_d = 1'b1;
            end
         end
         StScan: begin
            if (!tap_valid || cmd_ready) begin
               if (tap_valid) begin
                  first_d = 1'b0;
               end
               if (kw_q != KCW'(K - 1)) begin
                  kw_d = kw_q + 1'b1;
               end else begin
                  kw_d = '0;
                  if (kh_q != KCW'(K - 1)) begin
                     kh_d = kh_q + 1'b1;
                  end else begin
                     kh_d = '0;
                     if (kd_q != KCW'(K - 1)) begin
                        kd_d = kd_q + 1'b1;
                     end else begin
                        kd_d = '0;
                        ci_d = (ci_q != CICW'(CIN - 1)) ? ci_q + 1'b1 : '0;
                     end
                  end
               end
               if (last_tap) begin
                  state_d = StCommit;
               end
            end
         end
         StCommit: begin
            if (cmd_ready) begin
               first_d = 1'b1;
               state_d = last_vox ? StDone : StScan;
               if (ow_q != OCW'(OUT_SIZE - 1)) begin
                  ow_d = ow_q + 1'b1;
               end else begin
                  ow_d = '0;
                  if (oh_q != OCW'(OUT_SIZE - 1)) begin
                     oh_d = oh_q + 1'b1;
                  end else begin
                     oh_d = '0;
                     if (od_q != OCW'(OUT_SIZE - 1)) begin
                        od_d = od_q + 1'b1;
                     end else begin
                        od_d = '0;
                        co_d = (co_q != COCW'(COUT - 1)) ? co_q + 1'b1 : '0;
                     end
                  end
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      // Abort overrides everything, including a simultaneous start or handshake.
      if (abort) begin
         state_d = StIdle;
         co_d    = '0;
         od_d    = '0;
         oh_d    = '0;
         ow_d    = '0;
         ci_d    = '0;
         kd_d    = '0;
         kh_d    = '0;
         kw_d    = '0;
         first_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         co_q    <= '0;
         od_q    <= '0;
         oh_q    <= '0;
         ow_q    <= '0;
         ci_q    <= '0;
         kd_q    <= '0;
         kh_q    <= '0;
         kw_q    <= '0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         co_q    <= co_d;
         od_q    <= od_d;
         oh_q    <= oh_d;
         ow_q    <= ow_d;
         ci_q    <= ci_d;
         kd_q    <= kd_d;
         kh_q    <= kh_d;
         kw_q    <= kw_d;
         first_q <= first_d;
      end
   end

endmodule

// File: tb/tb_conv_transpose3d_tap_scheduler.sv
// Directed bench for the transposed-conv tap scheduler: default geometry plus a second
// channelled configuration, checked against a gather-form command list and scatter-form relations.
module tb_conv_transpose3d_tap_scheduler;

   logic        clk = 1'b0;
   logic        rst_n, start, abort, cmd_ready;
   logic        busy, done, cmd_valid, cmd_op, cmd_first;
   logic [15:0] cmd_in_addr, cmd_w_addr, cmd_out_addr;

   logic        start2, abort2, cmd_ready2;
   logic        busy2, done2, cmd_valid2, cmd_op2, cmd_first2;
   logic [15:0] cmd_in_addr2, cmd_w_addr2, cmd_out_addr2;

   int errors = 0;
   int checks = 0;

   logic [49:0] exp_q[$];
   logic [49:0] log_q[$];
   int          t1_base, t1_len;

   logic        stall_prev = 1'b0;
   logic [49:0] stall_word = '0;
   int          unstable_cnt = 0;

   int   mac2 = 0, commit2 = 0, bad2 = 0, vox2 = 0;
   logic seen2 = 1'b0;

   always #5 clk = ~clk;

   conv_transpose3d_tap_scheduler dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .busy         (busy),
      .done         (done),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_first    (cmd_first),
      .cmd_in_addr  (cmd_in_addr),
      .cmd_w_addr   (cmd_w_addr),
      .cmd_out_addr (cmd_out_addr)
   );

   conv_transpose3d_tap_scheduler #(
      .IN_SIZE (3),
      .K       (2),
      .STRIDE  (1),
      .PAD     (0),
      .DIL     (1),
      .CIN     (2),
      .COUT    (2),
      .AW      (16)
   ) dut2 (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start2),
      .abort        (abort2),
      .busy         (busy2),
      .done         (done2),
      .cmd_valid    (cmd_valid2),
      .cmd_ready    (cmd_ready2),
      .cmd_op       (cmd_op2),
      .cmd_first    (cmd_first2),
      .cmd_in_addr  (cmd_in_addr2),
      .cmd_w_addr   (cmd_w_addr2),
      .cmd_out_addr (cmd_out_addr2)
   );

   // Entry: {op, first, in, w, out}; in/w are don't-care on COMMIT when masked.
   function automatic logic [49:0] pack_cmd(input logic op, input logic first,
                                            input logic [15:0] ia, input logic [15:0] wa,
                                            input logic [15:0] oa, input logic mask);
      if (mask && op) begin
         ia = '0;
         wa = '0;
      end
      return {op, first, ia, wa, oa};
   endfunction

   // Default geometry, one dimension: input index or -1 when the tap is invalid.
   function automatic int tap_idx(input int o, input int k);
      int n;
      n = o + 1 - 2 * k;
      if (n < 0 || (n % 2) != 0 || (n / 2) >= 4) return -1;
      return n / 2;
   endfunction

   // Scatter-form relation for the second configuration (o = i + k, stride 1, no pad).
   function automatic int viol2(input logic op, input logic first, input logic [15:0] ia,
                                input logic [15:0] wa, input logic [15:0] oa, input int vox,
                                input logic seen);
      int v, in, w, o;
      v  = 0;
      in = int'(ia);
      w  = int'(wa);
      o  = int'(oa);
      if (o != vox) v++;
      if (op) begin
         if (first) v++;
      end else begin
         if (o / 16 % 4 != in / 9 % 3 + w / 4 % 2) v++;
         if (o / 4 % 4 != in / 3 % 3 + w / 2 % 2) v++;
         if (o % 4 != in % 3 + w % 2) v++;
         if (in / 27 != w / 16) v++;
         if (w / 8 % 2 != o / 64) v++;
         if (first == seen) v++;
      end
      return v;
   endfunction

   always @(negedge clk) begin
      if (rst_n && cmd_valid && cmd_ready)
         log_q.push_back(pack_cmd(cmd_op, cmd_first, cmd_in_addr, cmd_w_addr, cmd_out_addr,
                                  1'b1));
      if (rst_n && stall_prev && cmd_valid &&
          pack_cmd(cmd_op, cmd_first, cmd_in_addr, cmd_w_addr, cmd_out_addr, 1'b0) !== stall_word)
         unstable_cnt <= unstable_cnt + 1;
      stall_prev <= rst_n && cmd_valid && !cmd_ready && !abort;
      stall_word <= pack_cmd(cmd_op, cmd_first, cmd_in_addr, cmd_w_addr, cmd_out_addr, 1'b0);
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         vox2  <= 0;
         seen2 <= 1'b0;
      end else if (cmd_valid2 && cmd_ready2) begin
         bad2 <= bad2 + viol2(cmd_op2, cmd_first2, cmd_in_addr2, cmd_w_addr2, cmd_out_addr2,
                              vox2, seen2);
         if (cmd_op2) begin
            commit2 <= commit2 + 1;
            vox2    <= (vox2 + 1) % 128;
            seen2   <= 1'b0;
         end else begin
            mac2  <= mac2 + 1;
            seen2 <= 1'b1;
         end
      end
   end

   task automatic build_expected();
      int id, ih, iw, out;
      logic fst;
      for (int od = 0; od < 9; od++)
         for (int oh = 0; oh < 9; oh++)
            for (int ow = 0; ow < 9; ow++) begin
               fst = 1'b1;
               out = (od * 9 + oh) * 9 + ow;
               for (int kd = 0; kd < 3; kd++)
                  for (int kh = 0; kh < 3; kh++)
                     for (int kw = 0; kw < 3; kw++) begin
                        id = tap_idx(od, kd);
                        ih = tap_idx(oh, kh);
                        iw = tap_idx(ow, kw);
                        if (id >= 0 && ih >= 0 && iw >= 0) begin
                           exp_q.push_back({1'b0, fst, 16'((id * 4 + ih) * 4 + iw),
                                            16'((kd * 3 + kh) * 3 + kw), 16'(out)});
                           fst = 1'b0;
                        end
                     end
               exp_q.push_back({1'b1, 1'b0, 16'd0, 16'd0, 16'(out)});
            end
   endtask

   task automatic start_pass1(input int low_pct);
      cmd_ready = ($urandom_range(0, 99) >= low_pct);
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Counts edges after the start edge until done; leaves the DUT back in IDLE.
   task automatic wait_done1(input int limit, input int low_pct, output int cyc,
                             output logic busy_at_done);
      cyc          = -1;
      busy_at_done = 1'bx;
      for (int c = 1; c <= limit; c++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            cyc          = c;
            busy_at_done = busy;
            break;
         end
         cmd_ready = ($urandom_range(0, 99) >= low_pct);
      end
      cmd_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic count_mismatch(input int base, input int len, output int mism);
      mism = 0;
      for (int i = 0; i < len; i++)
         if (i >= exp_q.size() || log_q[base + i] !== exp_q[i]) mism++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++;
      if ({cmd_valid, cmd_op, cmd_first} !== 3'b000) begin
         errors++;
         $display("FAIL reset_cmd_flags got %b want 000", {cmd_valid, cmd_op, cmd_first});
      end
      checks++;
      if ({cmd_in_addr, cmd_w_addr, cmd_out_addr} !== 48'd0) begin
         errors++;
         $display("FAIL reset_addr got %h want 0", {cmd_in_addr, cmd_w_addr, cmd_out_addr});
      end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, cmd_valid, busy2, cmd_valid2} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_idle got %b want 0000", {busy, cmd_valid, busy2, cmd_valid2});
      end
   endtask

   task automatic test_defaults();
      int cyc, mism, mac91, first91, v91, first_mac91, cnt0, ent;
      logic bad;
      logic [49:0] e;
      t1_base = log_q.size();
      start_pass1(0);
      wait_done1(25000, 0, cyc, bad);
      checks++;
      if (cyc !== 20412) begin errors++; $display("FAIL done_cycle got %0d want 20412", cyc); end
      checks++;
      if (bad !== 1'b0) begin errors++; $display("FAIL busy_at_done got %b want 0", bad); end
      t1_len = log_q.size() - t1_base;
      checks++;
      if (t1_len != exp_q.size()) begin
         errors++;
         $display("FAIL cmd_count got %0d want %0d", t1_len, exp_q.size());
      end
      count_mismatch(t1_base, t1_len, mism);
      checks++;
      if (mism != 0) begin errors++; $display("FAIL cmd_sequence mismatches got %0d want 0", mism); end
      mac91 = 0; first91 = 0; v91 = 0; first_mac91 = -1; cnt0 = 0; ent = 0;
      for (int i = 0; i < t1_len; i++) begin
         e = log_q[t1_base + i];
         if (e[15:0] == 16'd91 && !e[49]) begin
            if (first_mac91 < 0) first_mac91 = int'(e[48]);
            mac91++;
            if (e[48]) first91++;
            if (e[47:32] / 16 > 1 || e[47:32] / 4 % 4 > 1 || e[47:32] % 4 > 1 ||
                e[31:16] / 9 > 1 || e[31:16] / 3 % 3 > 1 || e[31:16] % 3 > 1) v91++;
         end
         if (e[15:0] == 16'd0) begin
            cnt0++;
            if (e[49]) ent++;
         end
      end
      checks++;
      if (mac91 != 8) begin errors++; $display("FAIL out111_macs got %0d want 8", mac91); end
      checks++;
      if (first91 != 1 || first_mac91 != 1) begin
         errors++;
         $display("FAIL out111_first got count %0d lead %0d want 1 1", first91, first_mac91);
      end
      checks++;
      if (v91 != 0) begin errors++; $display("FAIL out111_taps out-of-range got %0d want 0", v91); end
      checks++;
      if (cnt0 != 1 || ent != 1) begin
         errors++;
         $display("FAIL out000_commit_only got %0d cmds %0d commits want 1 1", cnt0, ent);
      end
   endtask

   task automatic test_totals();
      int macs, commits, scat;
      logic [49:0] e;
      int id, ih, iw, kd, kh, kw, od, oh, ow;
      macs = 0; commits = 0; scat = 0;
      for (int i = 0; i < t1_len; i++) begin
         e = log_q[t1_base + i];
         if (e[49]) begin
            commits++;
         end else begin
            macs++;
            id = int'(e[47:32]) / 16 % 4; ih = int'(e[47:32]) / 4 % 4; iw = int'(e[47:32]) % 4;
            kd = int'(e[31:16]) / 9;      kh = int'(e[31:16]) / 3 % 3; kw = int'(e[31:16]) % 3;
            od = int'(e[15:0]) / 81;      oh = int'(e[15:0]) / 9 % 9;  ow = int'(e[15:0]) % 9;
            if (od != 2 * id - 1 + 2 * kd || oh != 2 * ih - 1 + 2 * kh || ow != 2 * iw - 1 + 2 * kw)
               scat++;
         end
      end
      checks++;
      if (macs != 1000) begin errors++; $display("FAIL total_macs got %0d want 1000", macs); end
      checks++;
      if (commits != 729) begin errors++; $display("FAIL total_commits got %0d want 729", commits); end
      checks++;
      if (scat != 0) begin errors++; $display("FAIL scatter_relation violations got %0d want 0", scat); end
   endtask

   task automatic test_random_ready();
      int cyc, base, len, mism, unst0;
      logic bad;
      base  = log_q.size();
      unst0 = unstable_cnt;
      start_pass1(30);
      wait_done1(45000, 30, cyc, bad);
      checks++;
      if (cyc < 20412) begin errors++; $display("FAIL rnd_done_cycle got %0d want >=20412", cyc); end
      len = log_q.size() - base;
      checks++;
      if (len != exp_q.size()) begin
         errors++;
         $display("FAIL rnd_cmd_count got %0d want %0d", len, exp_q.size());
      end
      count_mismatch(base, len, mism);
      checks++;
      if (mism != 0) begin errors++; $display("FAIL rnd_sequence mismatches got %0d want 0", mism); end
      checks++;
      if (unstable_cnt != unst0) begin
         errors++;
         $display("FAIL rnd_stall_stable changes got %0d want 0", unstable_cnt - unst0);
      end
   endtask

   task automatic test_abort();
      int base, dn;
      base = log_q.size();
      start_pass1(0);
      for (int c = 0; c < 5000; c++) begin
         if (log_q.size() - base >= 99) break;
         @(posedge clk); #1;
      end
      cmd_ready = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (cmd_valid) break;
         @(posedge clk); #1;
      end
      checks++;
      if ({cmd_valid, cmd_op, cmd_out_addr} !== {1'b1, exp_q[99][49], exp_q[99][15:0]}) begin
         errors++;
         $display("FAIL abort_cmd100 got %b/%b/%0d want 1/%b/%0d", cmd_valid, cmd_op,
                  cmd_out_addr, exp_q[99][49], exp_q[99][15:0]);
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      checks++;
      if ({cmd_valid, busy} !== 2'b00) begin
         errors++;
         $display("FAIL abort_idle valid/busy got %b want 00", {cmd_valid, busy});
      end
      dn = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (done) dn++;
      end
      checks++;
      if (dn != 0 || log_q.size() - base != 99) begin
         errors++;
         $display("FAIL abort_no_done got done %0d cmds %0d want 0 99", dn, log_q.size() - base);
      end
      base = log_q.size();
      start_pass1(0);
      for (int c = 0; c < 200; c++) begin
         if (log_q.size() > base) break;
         @(posedge clk); #1;
      end
      checks++;
      if (log_q.size() <= base || log_q[base] !== exp_q[0]) begin
         errors++;
         $display("FAIL abort_replay got %h want %h", (log_q.size() > base) ? log_q[base] : 50'h0,
                  exp_q[0]);
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({busy, cmd_valid} !== 2'b00) begin
         errors++;
         $display("FAIL start_abort_same got busy/valid %b want 00", {busy, cmd_valid});
      end
   endtask

   task automatic test_config2();
      int cyc, m0, c0, b0;
      m0 = mac2; c0 = commit2; b0 = bad2;
      cmd_ready2 = 1'b1;
      start2     = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      cyc    = -1;
      for (int c = 1; c <= 5000; c++) begin
         @(posedge clk); #1;
         if (done2 === 1'b1) begin cyc = c; break; end
      end
      @(posedge clk); #1;
      checks++;
      if (cyc != 2176) begin errors++; $display("FAIL cfg2_done_cycle got %0d want 2176", cyc); end
      checks++;
      if (mac2 - m0 != 864) begin errors++; $display("FAIL cfg2_macs got %0d want 864", mac2 - m0); end
      checks++;
      if (commit2 - c0 != 128) begin
         errors++;
         $display("FAIL cfg2_commits got %0d want 128", commit2 - c0);
      end
      checks++;
      if (bad2 - b0 != 0) begin errors++; $display("FAIL cfg2_addr_relation got %0d want 0", bad2 - b0); end
   endtask

   task automatic test_stray_start_and_reset();
      int base, len, mism, act;
      base = log_q.size();
      start_pass1(0);
      for (int c = 1; c <= 300; c++) begin
         start = (c >= 100 && c < 103);
         @(posedge clk); #1;
      end
      start = 1'b0;
      len   = log_q.size() - base;
      count_mismatch(base, len, mism);
      checks++;
      if (len < 5 || mism != 0) begin
         errors++;
         $display("FAIL stray_start prefix got len %0d mism %0d want >=5 0", len, mism);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({busy, done, cmd_valid, cmd_op, cmd_first} !== 5'b0 ||
          {cmd_in_addr, cmd_w_addr, cmd_out_addr} !== 48'd0) begin
         errors++;
         $display("FAIL midpass_reset got %b %h want 0 0", {busy, done, cmd_valid, cmd_op, cmd_first},
                  {cmd_in_addr, cmd_w_addr, cmd_out_addr});
      end
      rst_n = 1'b1;
      act   = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (busy || cmd_valid || done) act++;
      end
      checks++;
      if (act != 0) begin errors++; $display("FAIL post_reset_idle active cycles got %0d want 0", act); end
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      cmd_ready  = 1'b1;
      start2     = 1'b0;
      abort2     = 1'b0;
      cmd_ready2 = 1'b1;
      build_expected();
      test_reset();
      test_defaults();
      test_totals();
      test_random_ready();
      test_abort();
      test_config2();
      test_stray_start_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
